// File: rtl/level_bar_pkg.sv
// level_bar_pkg: shared types and constants for the LED level bar controller.
//   state_e : key FSM states (IDLE, HOLD, REPEAT)
//   dir_e   : direction latched for the active key
//   KEY_*   : bit positions of the increment/decrement keys
//   MODE_*  : LEDR decode styles
package level_bar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } state_e;

    typedef enum logic {
        DIR_INC = 1'b0,
        DIR_DEC = 1'b1
    } dir_e;

    localparam int unsigned KEY_INC  = 0;
    localparam int unsigned KEY_DEC  = 1;

    localparam int unsigned MODE_BAR = 0;
    localparam int unsigned MODE_DOT = 1;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/level_bar_key_sync.sv
// level_bar_key_sync: 2-flop synchronizer for the two active-low keys.
//   clk, rst_n : clock and synchronous active-low reset (flops reset to released)
//   key_n      : raw active-low keys, asynchronous to clk
//   pressed    : synchronized, active-high pressed bits
module level_bar_key_sync (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] key_n,
    output logic [1:0] pressed
);

    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign pressed = ~sync2_q;

endmodule

// File: rtl/level_bar.sv
// level_bar: push-button level controller driving the board LED bar.
//   CLOCK_50 : sole clock, rising edge
//   RESET_N  : synchronous active-low reset
//   KEY      : active-low keys, [0] increment, [1] decrement (asynchronous)
//   LEDR     : bar-fill or single-dot decode of the level
//   level    : current level, 0..WIDTH
//   at_max   : level == WIDTH
//   at_min   : level == 0
//   step     : one-cycle pulse whenever the level register changes
// Build option: LEVEL_BAR_AUTOREPEAT_EN enables hold-to-repeat; without it
// each press yields exactly one step.
module level_bar
    import level_bar_pkg::*;
#(
    parameter int unsigned WIDTH         = 10,
    parameter int unsigned INIT_LEVEL    = 5,
    parameter int unsigned HOLD_CYCLES   = 25000000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned WRAP          = 0,
    parameter int unsigned MODE          = 0,
    localparam int unsigned LVL_W        = $clog2(WIDTH + 1)
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic [1:0]       KEY,
    output logic [WIDTH-1:0] LEDR,
    output logic [LVL_W-1:0] level,
    output logic             at_max,
    output logic             at_min,
    output logic             step
);

    if (INIT_LEVEL > WIDTH || HOLD_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_param
        $error("level_bar: illegal parameter combination");
    end

    logic [1:0] pressed;

    level_bar_key_sync u_key_sync (
        .clk     (CLOCK_50),
        .rst_n   (RESET_N),
        .key_n   (KEY),
        .pressed (pressed)
    );

    state_e           state_q, state_d;
    dir_e             dir_q, dir_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             step_q, step_d;
    logic             do_step;
    dir_e             step_dir;
    logic             active_held;

`ifdef LEVEL_BAR_AUTOREPEAT_EN
    localparam int unsigned TIMER_W = $clog2(max_u(HOLD_CYCLES, REPEAT_CYCLES) + 1);
    logic [TIMER_W-1:0] timer_q, timer_d;
`endif

    assign active_held = (dir_q == DIR_DEC) ? pressed[KEY_DEC] : pressed[KEY_INC];

    // Key FSM: decides when a step is issued and in which direction.
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        do_step  = 1'b0;
        step_dir = dir_q;
`ifdef LEVEL_BAR_AUTOREPEAT_EN
        timer_d  = timer_q;
`endif
        case (state_q)
            IDLE: begin
                // Both keys together is ambiguous and ignored.
                if (pressed[KEY_INC] ^ pressed[KEY_DEC]) begin
                    do_step  = 1'b1;
                    step_dir = pressed[KEY_DEC] ? DIR_DEC : DIR_INC;
                    dir_d    = step_dir;
                    state_d  = HOLD;
`ifdef LEVEL_BAR_AUTOREPEAT_EN
                    timer_d  = '0;
`endif
                end
            end
            HOLD: begin
                if (!active_held) begin
                    state_d = IDLE;
`ifdef LEVEL_BAR_AUTOREPEAT_EN
                end else if (timer_q == TIMER_W'(HOLD_CYCLES - 1)) begin
                    do_step = 1'b1;
                    timer_d = '0;
                    state_d = REPEAT;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
`endif
                end
            end
`ifdef LEVEL_BAR_AUTOREPEAT_EN
            REPEAT: begin
                if (!active_held) begin
                    state_d = IDLE;
                end else if (timer_q == TIMER_W'(REPEAT_CYCLES - 1)) begin
                    do_step = 1'b1;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Level update; a saturated step leaves the level alone and does not pulse.
    always_comb begin
        level_d = level_q;
        if (do_step) begin
            if (step_dir == DIR_INC) begin
                if (level_q < LVL_W'(WIDTH))  level_d = level_q + LVL_W'(1);
                else if (WRAP != 0)           level_d = '0;
            end else begin
                if (level_q != '0)            level_d = level_q - LVL_W'(1);
                else if (WRAP != 0)           level_d = LVL_W'(WIDTH);
            end
        end
        step_d = (level_d != level_q);
    end

    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            dir_q   <= DIR_INC;
            level_q <= LVL_W'(INIT_LEVEL);
            step_q  <= 1'b0;
`ifdef LEVEL_BAR_AUTOREPEAT_EN
            timer_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            level_q <= level_d;
            step_q  <= step_d;
`ifdef LEVEL_BAR_AUTOREPEAT_EN
            timer_q <= timer_d;
`endif
        end
    end

    // LED decode: bar lights the top `level` LEDs, dot lights only the lowest of them.
    always_comb begin
        LEDR = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (level_q != '0) begin
                if (MODE == MODE_DOT) LEDR[i] = (i == int'(WIDTH) - int'(level_q));
                else                  LEDR[i] = (i >= int'(WIDTH) - int'(level_q));
            end
        end
    end

    assign level  = level_q;
    assign step   = step_q;
    assign at_max = (level_q == LVL_W'(WIDTH));
    assign at_min = (level_q == '0);

endmodule

// File: tb/tb_level_bar.sv
module tb_level_bar;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] key;

    logic [3:0] ledr_a, ledr_w, ledr_m;
    logic [2:0] lvl_a, lvl_w, lvl_m;
    logic       max_a, max_w, max_m;
    logic       min_a, min_w, min_m;
    logic       stp_a, stp_w, stp_m;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    level_bar #(.WIDTH(4), .INIT_LEVEL(2), .HOLD_CYCLES(4), .REPEAT_CYCLES(2),
                .WRAP(0), .MODE(0)) dut_a (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .LEDR(ledr_a),
        .level(lvl_a), .at_max(max_a), .at_min(min_a), .step(stp_a));

    level_bar #(.WIDTH(4), .INIT_LEVEL(0), .HOLD_CYCLES(4), .REPEAT_CYCLES(2),
                .WRAP(1), .MODE(0)) dut_w (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .LEDR(ledr_w),
        .level(lvl_w), .at_max(max_w), .at_min(min_w), .step(stp_w));

    level_bar #(.WIDTH(4), .INIT_LEVEL(2), .HOLD_CYCLES(4), .REPEAT_CYCLES(2),
                .WRAP(0), .MODE(1)) dut_m (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY(key), .LEDR(ledr_m),
        .level(lvl_m), .at_max(max_m), .at_min(min_m), .step(stp_m));

    // Advance one rising edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        key   = 2'b11;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (lvl_a !== 3'd2)     begin errors++; $display("FAIL reset_level got %0d want 2", lvl_a); end
        checks++; if (ledr_a !== 4'b1100) begin errors++; $display("FAIL reset_ledr got %b want 1100", ledr_a); end
        checks++; if (min_a !== 1'b0)     begin errors++; $display("FAIL reset_at_min got %b want 0", min_a); end
        checks++; if (max_a !== 1'b0)     begin errors++; $display("FAIL reset_at_max got %b want 0", max_a); end
        checks++; if (stp_a !== 1'b0)     begin errors++; $display("FAIL reset_step got %b want 0", stp_a); end
        checks++; if (min_w !== 1'b1 || ledr_w !== 4'b0000)
            begin errors++; $display("FAIL reset_wrap_inst got min=%b ledr=%b want 1 0000", min_w, ledr_w); end
        checks++; if (ledr_m !== 4'b0100) begin errors++; $display("FAIL reset_dot_ledr got %b want 0100", ledr_m); end
    endtask

`ifdef LEVEL_BAR_AUTOREPEAT_EN
    // KEY[0] held 12 edges: steps at 3 and 7, saturated (silent) at 9 and 11.
    task automatic test_autorepeat();
        logic [2:0] exp_lvl;
        logic       exp_stp;
        do_reset();
        key = 2'b10;
        for (int e = 1; e <= 12; e++) begin
            tick();
            exp_lvl = (e < 3) ? 3'd2 : (e < 7) ? 3'd3 : 3'd4;
            exp_stp = (e == 3) || (e == 7);
            checks++; if (lvl_a !== exp_lvl) begin errors++; $display("FAIL repeat_level edge %0d got %0d want %0d", e, lvl_a, exp_lvl); end
            checks++; if (stp_a !== exp_stp) begin errors++; $display("FAIL repeat_step edge %0d got %b want %b", e, stp_a, exp_stp); end
        end
        checks++; if (max_a !== 1'b1)     begin errors++; $display("FAIL repeat_at_max got %b want 1", max_a); end
        checks++; if (ledr_a !== 4'b1111) begin errors++; $display("FAIL repeat_ledr got %b want 1111", ledr_a); end
        key = 2'b11;
    endtask
`else
    // KEY[1] held 20 edges: exactly one step, 2 -> 1 at edge 3.
    task automatic test_single_step();
        int nsteps = 0;
        do_reset();
        key = 2'b01;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (stp_a === 1'b1) nsteps++;
            if (e == 2) begin
                checks++; if (lvl_a !== 3'd2) begin errors++; $display("FAIL single_early got %0d want 2", lvl_a); end
            end
            if (e == 3) begin
                checks++; if (lvl_a !== 3'd1 || stp_a !== 1'b1)
                    begin errors++; $display("FAIL single_edge3 got lvl=%0d stp=%b want 1 1", lvl_a, stp_a); end
            end
        end
        checks++; if (nsteps != 1 || lvl_a !== 3'd1)
            begin errors++; $display("FAIL single_total got steps=%0d lvl=%0d want 1 1", nsteps, lvl_a); end
        key = 2'b11;
        for (int e = 0; e < 4; e++) tick();
    endtask
`endif

    // WRAP instance at 0, decrement wraps to WIDTH with one step pulse.
    task automatic test_wrap();
        do_reset();
        key = 2'b01;
        tick();
        tick();
        checks++; if (lvl_w !== 3'd0 || stp_w !== 1'b0)
            begin errors++; $display("FAIL wrap_edge2 got lvl=%0d stp=%b want 0 0", lvl_w, stp_w); end
        tick();
        checks++; if (lvl_w !== 3'd4)  begin errors++; $display("FAIL wrap_level got %0d want 4", lvl_w); end
        checks++; if (stp_w !== 1'b1)  begin errors++; $display("FAIL wrap_step got %b want 1", stp_w); end
        checks++; if (max_w !== 1'b1 || ledr_w !== 4'b1111)
            begin errors++; $display("FAIL wrap_flags got max=%b ledr=%b want 1 1111", max_w, ledr_w); end
        key = 2'b11;
        tick();
        checks++; if (stp_w !== 1'b0)  begin errors++; $display("FAIL wrap_pulse_width got %b want 0", stp_w); end
        for (int e = 0; e < 4; e++) tick();
    endtask

    task automatic test_both_keys();
        do_reset();
        key = 2'b00;
        for (int e = 1; e <= 10; e++) begin
            tick();
            checks++; if (lvl_a !== 3'd2 || stp_a !== 1'b0)
                begin errors++; $display("FAIL both_keys edge %0d got lvl=%0d stp=%b want 2 0", e, lvl_a, stp_a); end
        end
        key = 2'b11;
        for (int e = 0; e < 4; e++) tick();
    endtask

    task automatic test_dot_mode();
        do_reset();
        key = 2'b10;
        tick();
        tick();
        tick();
        key = 2'b11;
        checks++; if (lvl_m !== 3'd3)     begin errors++; $display("FAIL dot_level got %0d want 3", lvl_m); end
        checks++; if (ledr_m !== 4'b0010) begin errors++; $display("FAIL dot_ledr got %b want 0010", ledr_m); end
        for (int e = 0; e < 4; e++) tick();
    endtask

    // Separate presses down to 0, then one more press is saturated and silent.
    task automatic test_back_to_back();
        int nsteps;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            nsteps = 0;
            key = 2'b01;
            for (int e = 0; e < 3; e++) begin tick(); if (stp_a === 1'b1) nsteps++; end
            key = 2'b11;
            for (int e = 0; e < 4; e++) begin tick(); if (stp_a === 1'b1) nsteps++; end
            checks++; if (nsteps != ((p < 2) ? 1 : 0))
                begin errors++; $display("FAIL b2b_steps press %0d got %0d want %0d", p, nsteps, (p < 2) ? 1 : 0); end
        end
        checks++; if (lvl_a !== 3'd0 || min_a !== 1'b1 || ledr_a !== 4'b0000)
            begin errors++; $display("FAIL b2b_min got lvl=%0d min=%b ledr=%b want 0 1 0000", lvl_a, min_a, ledr_a); end
    endtask

    // Reset while the key is held in HOLD; held key acts as a fresh press afterwards.
    task automatic test_reset_mid_hold();
        do_reset();
        key = 2'b01;
        for (int e = 0; e < 5; e++) tick();
        checks++; if (lvl_a !== 3'd1) begin errors++; $display("FAIL midhold_pre got %0d want 1", lvl_a); end
        rst_n = 1'b0;
        tick();
        tick();
        checks++; if (lvl_a !== 3'd2 || stp_a !== 1'b0)
            begin errors++; $display("FAIL midhold_reset got lvl=%0d stp=%b want 2 0", lvl_a, stp_a); end
        rst_n = 1'b1;
        tick();
        tick();
        checks++; if (lvl_a !== 3'd2) begin errors++; $display("FAIL midhold_edge2 got %0d want 2", lvl_a); end
        tick();
        checks++; if (lvl_a !== 3'd1 || stp_a !== 1'b1)
            begin errors++; $display("FAIL midhold_edge3 got lvl=%0d stp=%b want 1 1", lvl_a, stp_a); end
        key = 2'b11;
        for (int e = 0; e < 4; e++) tick();
    endtask

    initial begin
        key   = 2'b11;
        rst_n = 1'b0;
        test_reset();
`ifdef LEVEL_BAR_AUTOREPEAT_EN
        test_autorepeat();
`else
        test_single_step();
`endif
        test_wrap();
        test_both_keys();
        test_dot_mode();
        test_back_to_back();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/level_bar.md
# level_bar

Parametrised push-button level controller for the board LED bar. Two active-low keys step a level counter (0..WIDTH) up or down. Holding a key auto-repeats after an initial hold delay. The level is decoded onto LEDR as a fill bar or a single dot, with saturating or wrapping limits. It is the next generation of the DE-board LED bar controller and drives LEDR directly from the top level.

## Interface
- WIDTH, 10: number of LEDs; level range 0..WIDTH
- INIT_LEVEL, 5: level after reset; must be ≤ WIDTH
- HOLD_CYCLES, 25000000: cycles a key must stay held after the first step before auto-repeat starts
- REPEAT_CYCLES, 5000000: cycles between auto-repeat steps
- WRAP, 0: 0 = saturate at limits; 1 = wrap (WIDTH+1 → 0, 0−1 → WIDTH)
- MODE, 0: 0 = bar fill; 1 = single dot
- CLOCK_50  in  1  sole clock, rising edge
- RESET_N  in  1  synchronous, active-low reset
- KEY  in  2  active-low buttons; [0] = increment, [1] = decrement; asynchronous to CLOCK_50
- LEDR  out  WIDTH  decoded level display
- level  out  $clog2(WIDTH+1)  current level
- at_max  out  1  high when level == WIDTH
- at_min  out  1  high when level == 0
- step  out  1  one-cycle pulse on every cycle the level register changes

## Operation
- KEY passes through a 2-flop synchronizer; sync flops reset to 1 (released). A key is "pressed" when its synchronized value is 0.
- FSM states are IDLE, HOLD and REPEAT; register dir records which key is active.
- IDLE:
  - Exactly one key pressed: issue a step in that direction, latch dir, clear timer, go to HOLD.
  - Both keys or neither pressed: no action.
- HOLD:
  - Active key released: go to IDLE. The opposite key, if held, is then acted on from IDLE on the next cycle.
  - Otherwise timer increments. At timer == HOLD_CYCLES−1: issue a step, clear timer, go to REPEAT.
  - The opposite key is ignored while the active key is held.
- REPEAT:
  - Active key released: go to IDLE.
  - At timer == REPEAT_CYCLES−1: issue a step and clear timer.
- Step rules:
  - Increment: level < WIDTH → level+1. At WIDTH: wrap to 0 if WRAP, else no change.
  - Decrement: level > 0 → level−1. At 0: wrap to WIDTH if WRAP, else no change.
  - A suppressed (saturated) step does not pulse step; FSM and timer behave as if the step occurred.
- LEDR is a pure combinational decode of the level register:
  - MODE 0: bits [WIDTH−1 : WIDTH−level] set, all others clear.
  - MODE 1: only bit WIDTH−level set.
  - Level 0 gives all LEDs off in both modes.
- at_max and at_min are combinational from level.

## Timing
- Reset values: level = INIT_LEVEL, state = IDLE, timer = 0, step = 0. LEDR, at_max and at_min follow from INIT_LEVEL.
- Reset asserted mid-HOLD or mid-REPEAT discards the operation; the next cycle starts in IDLE.
- A key held through reset deassertion counts as a new press.
- Latency from key to level change:
  - The first edge sampling KEY low is edge 1.
  - Level and step update at edge 3.
  - LEDR changes in the same cycle as level.
- Auto-repeat timing: the second step lands HOLD_CYCLES edges after the first; later steps land every REPEAT_CYCLES edges.
- The timer must be at least $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)) bits wide; it never wraps.

## Configuration
- LEVEL_BAR_AUTOREPEAT_EN defined: full IDLE/HOLD/REPEAT behaviour as above.
- LEVEL_BAR_AUTOREPEAT_EN undefined:
  - REPEAT state and timer are not built.
  - HOLD only waits for the active key to release, so each press gives exactly one step.
  - HOLD_CYCLES and REPEAT_CYCLES are ignored.

## Structure
- Package level_bar_pkg holds:
  - state enum: IDLE, HOLD, REPEAT
  - KEY_INC = 0, KEY_DEC = 1
  - MODE_BAR = 0, MODE_DOT = 1
  - DIR_INC / DIR_DEC encoding
- One sub-module, level_bar_key_sync: 2-bit 2-flop synchronizer with reset-to-1, outputting active-high pressed bits.

## Test plan
Bench parameters unless stated: WIDTH=4, INIT_LEVEL=2, HOLD_CYCLES=4, REPEAT_CYCLES=2, macro defined.
- Reset → level=2, LEDR=4'b1100, at_min=0, at_max=0, step=0.
- KEY[0] low for 12 edges → level 3 at edge 3, level 4 at edge 7, no step at edges 9 and 11; at_max=1, LEDR=4'b1111.
- WRAP=1, level 0, KEY[1] pressed → level=4 at edge 3, step pulses once.
- Both keys driven low on the same edge from IDLE → no step; level unchanged for 10 cycles.
- MODE=1, single KEY[0] press from level 2 → level=3, LEDR=4'b0010.
- Macro undefined, KEY[1] held 20 edges → exactly one step (level 2→1). Separately, RESET_N low mid-HOLD with the key still held → level=2; first new step 3 edges after RESET_N rises.
